// File: rtl/esp8266_resp.sv
// ESP8266 AT-command responder: collects CR-LF terminated lines, answers with fixed
// strings at UART byte pacing, and forwards payload bytes in transparent mode.
module esp8266_resp #(
    parameter int CLK_FRE   = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int BYTE_GAP  = (CLK_FRE / BAUD_RATE) * 11,
    parameter int IDLE_TO   = (CLK_FRE / BAUD_RATE) * 100,
    parameter int LINE_MAX  = 64
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic [7:0] pass_data,
    output logic       pass_flag,
    output logic       trans_mode,
    output logic [7:0] ok_cnt
);
    localparam int CW = $clog2(LINE_MAX + 3);
    localparam int AW = $clog2(LINE_MAX);
    localparam int GW = $clog2(BYTE_GAP + 1);
    localparam int TW = $clog2(IDLE_TO + 1);
    localparam logic [95:0] S_MODE1 = "AT+CIPMODE=1";
    localparam logic [95:0] S_MODE0 = "AT+CIPMODE=0";
    localparam logic [79:0] S_SEND  = "AT+CIPSEND";

    typedef enum logic [1:0] {COLLECT, MATCH, RESP, TRANS} state_t;
    typedef enum logic [1:0] {R_OK, R_OKP, R_ERR, R_PP} resp_t;

    state_t        state_q, state_d;
    resp_t         rsel_q, rsel_d, msel;
    logic [7:0]    line_q [LINE_MAX];
    logic [CW-1:0] cnt_q, cnt_d, len;
    logic [TW-1:0] idle_q, idle_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [2:0]    idx_q, idx_d;
    logic [1:0]    plus_q, plus_d, flush_q, flush_d;
    logic [7:0]    pend_q, pend_d, po_data_q, po_data_d, pass_data_q, pass_data_d;
    logic [7:0]    ok_cnt_q, ok_cnt_d;
    logic          cr_q, cr_d, cip_q, cip_d, pend_v_q, pend_v_d, mcip;
    logic          po_flag_q, po_flag_d, pass_flag_q, pass_flag_d;
    logic          wr_en, line_end, idle_exp, is_ppp, ovf, gap_done, m1, m0, ms, mat;

    function automatic logic [7:0] resp_byte(input resp_t s, input logic [2:0] i);
        logic [55:0] err;
        err = {"ERROR", 8'h0D, 8'h0A};
        case (s)
            R_ERR:   resp_byte = err[8*(6-i) +: 8];
            R_PP:    resp_byte = "+";
            default: case (i)
                3'd0:    resp_byte = "O";
                3'd1:    resp_byte = "K";
                3'd2:    resp_byte = 8'h0D;
                3'd3:    resp_byte = 8'h0A;
                default: resp_byte = ">";
            endcase
        endcase
    endfunction

    function automatic logic [2:0] resp_last(input resp_t s);
        case (s)
            R_OK:    resp_last = 3'd3;
            R_OKP:   resp_last = 3'd4;
            R_ERR:   resp_last = 3'd6;
            default: resp_last = 3'd1;
        endcase
    endfunction

    // cnt_q counts the stored CR too and saturates one past an overflowing line
    assign len      = cnt_q - CW'(1);
    assign ovf      = cnt_q >= CW'(LINE_MAX + 2);
    assign line_end = pi_flag && (pi_data == 8'h0A) && cr_q;
    assign idle_exp = !pi_flag && (cnt_q != '0) && (idle_q == TW'(IDLE_TO - 1));
    assign is_ppp   = (cnt_q == CW'(3)) && (line_q[0] == "+") && (line_q[1] == "+") && (line_q[2] == "+");
    assign gap_done = gap_q == GW'(BYTE_GAP - 1);

    always_comb begin
        m1 = (len == CW'(12));
        m0 = (len == CW'(12));
        ms = (len == CW'(10));
        for (int unsigned i = 0; i < 12; i++) begin
            if (line_q[AW'(i)] != S_MODE1[8*(11-i) +: 8]) m1 = 1'b0;
            if (line_q[AW'(i)] != S_MODE0[8*(11-i) +: 8]) m0 = 1'b0;
        end
        for (int unsigned i = 0; i < 10; i++)
            if (line_q[AW'(i)] != S_SEND[8*(9-i) +: 8]) ms = 1'b0;
        mat  = (len >= CW'(2)) && (line_q[0] == "A") && (line_q[1] == "T");
        msel = R_ERR;
        mcip = cip_q;
        if (ovf)      msel = R_ERR;
        else if (m1)  begin msel = R_OK; mcip = 1'b1; end
        else if (m0)  begin msel = R_OK; mcip = 1'b0; end
        else if (ms)  msel = cip_q ? R_OKP : R_ERR;
        else if (mat) msel = R_OK;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= COLLECT;   rsel_q <= R_OK;    cnt_q <= '0;       idle_q <= '0;
            gap_q <= '0;          idx_q <= '0;       plus_q <= '0;      flush_q <= '0;
            pend_q <= '0;         pend_v_q <= 1'b0;  cr_q <= 1'b0;      cip_q <= 1'b0;
            po_data_q <= '0;      po_flag_q <= 1'b0; pass_data_q <= '0; pass_flag_q <= 1'b0;
            ok_cnt_q <= '0;
        end else begin
            state_q <= state_d;   rsel_q <= rsel_d;     cnt_q <= cnt_d;       idle_q <= idle_d;
            gap_q <= gap_d;       idx_q <= idx_d;       plus_q <= plus_d;     flush_q <= flush_d;
            pend_q <= pend_d;     pend_v_q <= pend_v_d; cr_q <= cr_d;         cip_q <= cip_d;
            po_data_q <= po_data_d; po_flag_q <= po_flag_d; pass_data_q <= pass_data_d;
            pass_flag_q <= pass_flag_d; ok_cnt_q <= ok_cnt_d;
        end
    end

    // Line storage needs no reset: only the first cnt_q entries are ever consulted
    always_ff @(posedge sys_clk) begin
        if (wr_en) line_q[AW'(cnt_q)] <= pi_data;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (line_end && cnt_q != CW'(1)) state_d = MATCH;
                     else if (idle_exp && is_ppp)     state_d = RESP;
            MATCH:   state_d = RESP;
            RESP:    if (gap_done && idx_q == resp_last(rsel_q))
                         state_d = (rsel_q == R_OKP) ? TRANS : COLLECT;
            TRANS:   if (pi_flag && flush_q == '0 && !pend_v_q && pi_data == "+" && plus_q == 2'd2)
                         state_d = RESP;
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        rsel_d = rsel_q;  cnt_d = cnt_q;  idle_d = idle_q;  gap_d = gap_q;  idx_d = idx_q;
        plus_d = plus_q;  flush_d = flush_q;  pend_d = pend_q;  pend_v_d = pend_v_q;
        cr_d = cr_q;  cip_d = cip_q;  ok_cnt_d = ok_cnt_q;  wr_en = 1'b0;
        po_data_d = po_data_q;  po_flag_d = 1'b0;  pass_data_d = pass_data_q;  pass_flag_d = 1'b0;
        case (state_q)
            COLLECT: begin
                if (pi_flag) begin
                    idle_d = '0;
                    if (line_end) begin
                        cr_d = 1'b0;
                        if (cnt_q == CW'(1)) cnt_d = '0;
                    end else begin
                        cr_d  = (pi_data == 8'h0D);
                        wr_en = cnt_q < CW'(LINE_MAX);
                        if (cnt_q < CW'(LINE_MAX + 2)) cnt_d = cnt_q + CW'(1);
                    end
                end else if (idle_exp) begin
                    cnt_d = '0;  cr_d = 1'b0;  idle_d = '0;
                    if (is_ppp) begin
                        rsel_d = R_PP;  po_data_d = "+";  po_flag_d = 1'b1;  idx_d = 3'd1;  gap_d = '0;
                    end
                end else if (cnt_q != '0) begin
                    idle_d = idle_q + TW'(1);
                end
            end
            MATCH: begin
                rsel_d = msel;  cip_d = mcip;  idx_d = 3'd1;  gap_d = '0;
                po_data_d = resp_byte(msel, 3'd0);  po_flag_d = 1'b1;
                if (msel == R_OK || msel == R_OKP) ok_cnt_d = ok_cnt_q + 8'd1;
            end
            RESP: begin
                if (gap_done) begin
                    gap_d = '0;  idx_d = idx_q + 3'd1;
                    po_data_d = resp_byte(rsel_q, idx_q);  po_flag_d = 1'b1;
                    if (idx_q == resp_last(rsel_q)) begin
                        cnt_d = '0;  cr_d = 1'b0;  idle_d = '0;  plus_d = '0;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            TRANS: begin
                // Bytes landing while held '+' are still being flushed are dropped
                if (pi_flag && flush_q == '0 && !pend_v_q) begin
                    if (pi_data == "+") begin
                        if (plus_q == 2'd2) begin
                            plus_d = '0;  cip_d = 1'b0;  rsel_d = R_PP;  idx_d = 3'd1;  gap_d = '0;
                            po_data_d = "+";  po_flag_d = 1'b1;
                        end else begin
                            plus_d = plus_q + 2'd1;
                        end
                    end else if (plus_q != '0) begin
                        pass_data_d = "+";  pass_flag_d = 1'b1;  flush_d = plus_q - 2'd1;
                        pend_d = pi_data;  pend_v_d = 1'b1;  plus_d = '0;
                    end else begin
                        pass_data_d = pi_data;  pass_flag_d = 1'b1;
                    end
                end else if (flush_q != '0) begin
                    pass_data_d = "+";  pass_flag_d = 1'b1;  flush_d = flush_q - 2'd1;
                end else if (pend_v_q) begin
                    pass_data_d = pend_q;  pass_flag_d = 1'b1;  pend_v_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        po_data    = po_data_q;
        po_flag    = po_flag_q;
        pass_data  = pass_data_q;
        pass_flag  = pass_flag_q;
        trans_mode = (state_q == TRANS);
        ok_cnt     = ok_cnt_q;
    end
endmodule

// File: tb/tb_esp8266_resp.sv
// Directed bench: one default-parameter instance for the full-rate AT timing, and a
// fast-gap instance for the command set, transparent mode, timeouts and reset.
module tb_esp8266_resp;
    localparam int FG = 16;
    localparam int FT = 200;
    localparam int SG = 4774;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pi_data = '0;
    logic       pf_s = 1'b0, pf_f = 1'b0;
    logic [7:0] po_data_s, pass_data_s, ok_cnt_s, po_data_f, pass_data_f, ok_cnt_f;
    logic       po_flag_s, pass_flag_s, trans_mode_s, po_flag_f, pass_flag_f, trans_mode_f;

    esp8266_resp u_slow (
        .sys_clk(clk), .sys_rst(rst), .pi_data(pi_data), .pi_flag(pf_s),
        .po_data(po_data_s), .po_flag(po_flag_s), .pass_data(pass_data_s),
        .pass_flag(pass_flag_s), .trans_mode(trans_mode_s), .ok_cnt(ok_cnt_s)
    );

    esp8266_resp #(.BYTE_GAP(FG), .IDLE_TO(FT)) u_fast (
        .sys_clk(clk), .sys_rst(rst), .pi_data(pi_data), .pi_flag(pf_f),
        .po_data(po_data_f), .po_flag(po_flag_f), .pass_data(pass_data_f),
        .pass_flag(pass_flag_f), .trans_mode(trans_mode_f), .ok_cnt(ok_cnt_f)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic [7:0] d; } ev_t;
    ev_t po_q[$];
    ev_t pass_q[$];

    always @(negedge clk) begin
        if (po_flag_f)   po_q.push_back('{c: cyc, d: po_data_f});
        if (po_flag_s)   po_q.push_back('{c: cyc, d: po_data_s});
        if (pass_flag_f) pass_q.push_back('{c: cyc, d: pass_data_f});
    end

    int checks = 0;
    int failures = 0;
    bit to_slow = 1'b0;
    int last_cyc = 0;
    int r;
    string s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        pi_data = b;
        if (to_slow) pf_s = 1'b1; else pf_f = 1'b1;
        last_cyc = cyc;
        @(posedge clk); #1;
        pf_s = 1'b0;
        pf_f = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_at(input logic [7:0] b, input int target);
        do begin @(posedge clk); #1; end while (cyc < target);
        pi_data = b;
        pf_f = 1'b1;
        last_cyc = cyc;
        @(posedge clk); #1;
        pf_f = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_str(input string str);
        for (int i = 0; i < str.len(); i++) send(str[i]);
    endtask

    task automatic expect_resp(input string tag, input string exp, input int first, input int gap);
        int n = exp.len();
        while (po_q.size() < n && cyc < first + n * gap + 20) @(negedge clk);
        check({tag, "_count"}, po_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < po_q.size()) begin
                check({tag, "_data"}, po_q[i].d, exp[i]);
                check({tag, "_cycle"}, po_q[i].c, first + i * gap);
            end
        end
        po_q.delete();
    endtask

    task automatic expect_pass(input string tag, input string exp, input int first);
        check({tag, "_count"}, pass_q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            if (i < pass_q.size()) begin
                check({tag, "_data"}, pass_q[i].d, exp[i]);
                check({tag, "_cycle"}, pass_q[i].c, first + i);
            end
        end
        pass_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_po_data"}, po_data_f, 0);
        check({tag, "_po_flag"}, po_flag_f, 0);
        check({tag, "_pass_data"}, pass_data_f, 0);
        check({tag, "_pass_flag"}, pass_flag_f, 0);
        check({tag, "_trans_mode"}, trans_mode_f, 0);
        check({tag, "_ok_cnt"}, ok_cnt_f, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk); #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Default parameters: full-rate byte spacing
        to_slow = 1'b1;
        send_str("AT\r\n");
        expect_resp("slow_at", "OK\r\n", last_cyc + 2, SG);
        check("slow_ok_cnt", ok_cnt_s, 1);
        to_slow = 1'b0;

        // Plain AT, po_data hold between strobes, byte dropped during RESP
        send_str("AT\r\n");
        r = last_cyc;
        repeat (5) @(negedge clk);
        check("hold_po_data", po_data_f, "O");
        send("Z");
        expect_resp("at", "OK\r\n", r + 2, FG);
        check("at_ok_cnt", ok_cnt_f, 1);

        send_str("AT+CIPMODE=1\r\n");
        expect_resp("mode1", "OK\r\n", last_cyc + 2, FG);
        check("mode1_ok_cnt", ok_cnt_f, 2);

        send_str("AT+CIPSEND\r\n");
        expect_resp("send_on", "OK\r\n>", last_cyc + 2, FG);
        @(negedge clk);
        check("send_on_trans", trans_mode_f, 1);
        check("send_on_ok_cnt", ok_cnt_f, 3);

        send("a"); expect_pass("pass_a", "a", last_cyc + 1);
        send("b"); expect_pass("pass_b", "b", last_cyc + 1);
        send("c"); expect_pass("pass_c", "c", last_cyc + 1);

        send("+"); expect_pass("plus_held", "", 0);
        send("a"); expect_pass("plus_flush", "+a", last_cyc + 1);

        send("+"); send("+"); send("+");
        expect_resp("exit_ppp", "++", last_cyc + 1, FG);
        @(negedge clk);
        check("exit_trans", trans_mode_f, 0);
        check("exit_ok_cnt", ok_cnt_f, 3);
        check("exit_no_pass", pass_q.size(), 0);

        send_str("HELLO\r\n");
        expect_resp("hello", "ERROR\r\n", last_cyc + 2, FG);

        s = "AT";
        for (int i = 0; i < 62; i++) s = {s, "x"};
        send_str({s, "\r\n"});
        expect_resp("len64", "OK\r\n", last_cyc + 2, FG);
        check("len64_ok_cnt", ok_cnt_f, 4);
        send_str({s, "x\r\n"});
        expect_resp("len65", "ERROR\r\n", last_cyc + 2, FG);
        send_str({s, "xxxxxx\r\n"});
        expect_resp("len70", "ERROR\r\n", last_cyc + 2, FG);
        check("ovf_ok_cnt", ok_cnt_f, 4);

        send_str("AT+CIPSEND\r\n");
        expect_resp("send_off", "ERROR\r\n", last_cyc + 2, FG);
        check("send_off_trans", trans_mode_f, 0);

        send_str("\r\n");
        repeat (3 * FG) @(negedge clk);
        check("empty_line", po_q.size(), 0);

        // CR lands in the very cycle the idle timer expires
        send_str("AT");
        send_at(8'h0D, last_cyc + FT);
        send(8'h0A);
        expect_resp("tmo_prec", "OK\r\n", last_cyc + 2, FG);
        check("tmo_prec_ok_cnt", ok_cnt_f, 5);

        send_str("+++");
        expect_resp("tmo_ppp", "++", last_cyc + FT + 1, FG);
        check("tmo_ppp_ok_cnt", ok_cnt_f, 5);
        send_str("AT\r\n");
        expect_resp("after_tmo", "OK\r\n", last_cyc + 2, FG);
        check("after_tmo_ok_cnt", ok_cnt_f, 6);

        // Reset after the second response byte
        send_str("AT\r\n");
        r = last_cyc;
        while (po_q.size() < 2 && cyc < r + FG + 20) @(negedge clk);
        check("pre_rst_bytes", po_q.size(), 2);
        check("pre_rst_ok_cnt", ok_cnt_f, 7);
        po_q.delete();
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_rst");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (4 * FG) @(negedge clk);
        check("post_rst_silent", po_q.size(), 0);
        check_outputs_zero("post_rst");
        send_str("AT\r\n");
        expect_resp("post_rst_at", "OK\r\n", last_cyc + 2, FG);
        check("post_rst_ok_cnt", ok_cnt_f, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
